// File: rtl/axi4_ram_model.sv
// Behavioural AXI4 memory slave: one outstanding burst per direction, FIXED/INCR/WRAP
// bursts, programmable read latency and SLVERR on beats outside the memory window.
module axi4_ram_model #(
  parameter int                    ADDR_WIDTH = 48,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ID_WIDTH   = 4,
  parameter int                    DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    RD_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rstn,
  // write address
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  // write data
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  // write response
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  // read address
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  // read data
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SHIFT  = $clog2(STRB_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  function automatic logic [ADDR_WIDTH-1:0] align(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ~ADDR_WIDTH'(STRB_W - 1);
  endfunction

  // WRAP keeps the bits above the (len+1)-beat block and lets the low bits roll over.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0]            len,
                                                      input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] mask;
    step = addr + ADDR_WIDTH'(STRB_W);
    mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << SHIFT) - ADDR_WIDTH'(1);
    if (burst == BURST_FIXED) return addr;
    if (burst == BURST_WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      return (addr & ~mask) | (step & mask);
    return step;
  endfunction

  // Addresses below BASE_ADDR wrap to a huge offset and so fall out of range too.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] offset;
    offset = addr - BASE_ADDR;
    return (offset >> SHIFT) < ADDR_WIDTH'(DEPTH);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> SHIFT);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------- write side
  w_state_t              w_state;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len;
  logic [7:0]            w_cnt;
  logic [1:0]            w_burst;
  logic                  w_err;

  logic w_hs;
  logic w_ok;
  logic w_last_beat;
  logic w_beat_err;

  assign w_hs        = s_axi_wvalid && s_axi_wready;
  assign w_ok        = in_range(w_addr);
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_err  = !w_ok || (s_axi_wlast != w_last_beat);

  // NOTE: non-blocking updates let the read path sample mem before this edge's write
  // lands, which is exactly the read-before-write ordering wanted for a shared word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state       <= W_IDLE;
      s_axi_awready <= 1'b1;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      w_id          <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_burst       <= '0;
      w_err         <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid && s_axi_awready) begin
            w_id          <= s_axi_awid;
            w_addr        <= align(s_axi_awaddr);
            w_len         <= s_axi_awlen;
            w_burst       <= s_axi_awburst;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b1;
            w_state       <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (w_last_beat) begin
              s_axi_wready <= 1'b0;
              s_axi_bvalid <= 1'b1;
              s_axi_bid    <= w_id;
              s_axi_bresp  <= (w_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state      <= W_RESP;
            end else begin
              w_err  <= w_err || w_beat_err;
              w_addr <= next_addr(w_addr, w_len, w_burst);
              w_cnt  <= w_cnt + 8'd1;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            s_axi_awready <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset; contents survive rstn and a reset loop over
  // DEPTH words would be pointless for a simulation model.
  always_ff @(posedge clk) begin
    if (w_hs && w_ok) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi_wstrb[b]) mem[word_idx(w_addr)][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read side
  r_state_t              r_state;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [1:0]            r_burst;
  logic [LAT_W-1:0]      lat_cnt;

  logic [ADDR_WIDTH-1:0] r_next;
  logic [ADDR_WIDTH-1:0] pres_addr;
  logic                  pres_last;
  logic                  pres_ok;
  logic [DATA_WIDTH-1:0] pres_data;

  assign r_next = next_addr(r_addr, r_len, r_burst);

  // Beat to present on the next edge: beat 0 when leaving R_WAIT, else the following beat.
  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    pres_addr = r_addr;
    pres_last = (r_cnt == r_len);
    if (r_state == R_DATA) begin
      pres_addr = r_next;
      pres_last = (r_cnt + 8'd1 == r_len);
    end
    pres_ok   = in_range(pres_addr);
    pres_data = pres_ok ? mem[word_idx(pres_addr)] : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= R_IDLE;
      s_axi_arready <= 1'b1;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      s_axi_rdata   <= '0;
      r_id          <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_burst       <= '0;
      lat_cnt       <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid && s_axi_arready) begin
            r_id          <= s_axi_arid;
            r_addr        <= align(s_axi_araddr);
            r_len         <= s_axi_arlen;
            r_burst       <= s_axi_arburst;
            r_cnt         <= '0;
            lat_cnt       <= LAT_W'(RD_LATENCY - 1);
            s_axi_arready <= 1'b0;
            r_state       <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (lat_cnt == '0) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rid    <= r_id;
            s_axi_rdata  <= pres_data;
            s_axi_rresp  <= pres_ok ? RESP_OKAY : RESP_SLVERR;
            s_axi_rlast  <= pres_last;
            r_state      <= R_DATA;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        R_DATA: begin
          if (s_axi_rvalid && s_axi_rready) begin
            if (r_cnt == r_len) begin
              s_axi_rvalid  <= 1'b0;
              s_axi_rlast   <= 1'b0;
              s_axi_arready <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_addr      <= r_next;
              r_cnt       <= r_cnt + 8'd1;
              s_axi_rdata <= pres_data;
              s_axi_rresp <= pres_ok ? RESP_OKAY : RESP_SLVERR;
              s_axi_rlast <= pres_last;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_ram_model.sv
// Directed bench for axi4_ram_model: a word-level memory model predicts every B and R
// beat, and one negedge process compares the DUT against those predictions.
`timescale 1ns/1ps
module tb_axi4_ram_model;

  localparam int              AW    = 48;
  localparam int              DW    = 64;
  localparam int              IW    = 4;
  localparam int              DEPTH = 4096;
  localparam int              RDL   = 2;
  localparam longint unsigned BYTES = 8;
  localparam longint unsigned BASE  = 0;

  logic          clk = 1'b0;
  logic          rstn;
  logic [IW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]    s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic [1:0]    s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;

  axi4_ram_model #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH),
    .BASE_ADDR(AW'(BASE)), .RD_LATENCY(RDL)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string what);
    checks++;
    errors++;
    $display("FAIL %s: no handshake within the cycle bound", what);
    $fatal(1, "bench stopped: %s", what);
  endtask

  // ------------------------------------------------------------------ model
  typedef struct { logic [IW-1:0] id; logic [63:0] data; logic [1:0] resp; logic last; } rbeat_t;
  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } bbeat_t;

  logic [63:0] mdl [longint unsigned];
  rbeat_t      exp_r[$];
  bbeat_t      exp_b[$];

  // i-th beat address straight from the burst definition (closed form, not iterative).
  function automatic longint unsigned beat_addr(input longint unsigned a, input int len,
                                                input logic [1:0] burst, input int i);
    longint unsigned al, sz, lo;
    al = a - (a % BYTES);
    sz = 64'(len + 1) * BYTES;
    if (burst == 2'd0) return al;
    if (burst == 2'd2 && len inside {1, 3, 7, 15}) begin
      lo = al - (al % sz);
      return lo + ((al - lo + 64'(i) * BYTES) % sz);
    end
    return al + 64'(i) * BYTES;
  endfunction

  function automatic bit in_rng(input longint unsigned a);
    return ((a - BASE) / BYTES) < 64'(DEPTH);
  endfunction

  function automatic logic [63:0] model_read(input longint unsigned a);
    longint unsigned k = (a - BASE) / BYTES;
    return mdl.exists(k) ? mdl[k] : 64'h0;
  endfunction

  function automatic void model_write(input longint unsigned a, input logic [63:0] d,
                                      input logic [7:0] s);
    longint unsigned k = (a - BASE) / BYTES;
    logic [63:0] w = mdl.exists(k) ? mdl[k] : 64'h0;
    for (int b = 0; b < 8; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
    mdl[k] = w;
  endfunction

  // --------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (s_axi_rvalid) begin
        if (exp_r.size() == 0) check("r_extra_rvalid", s_axi_rvalid, 1'b0);
        else begin
          check("rid",   s_axi_rid,   exp_r[0].id);
          check("rdata", s_axi_rdata, exp_r[0].data);
          check("rresp", s_axi_rresp, exp_r[0].resp);
          check("rlast", s_axi_rlast, exp_r[0].last);
          if (s_axi_rready) void'(exp_r.pop_front());
        end
      end
      if (s_axi_bvalid) begin
        if (exp_b.size() == 0) check("b_extra_bvalid", s_axi_bvalid, 1'b0);
        else begin
          check("bid",   s_axi_bid,   exp_b[0].id);
          check("bresp", s_axi_bresp, exp_b[0].resp);
          if (s_axi_bready) void'(exp_b.pop_front());
        end
      end
    end
  end

  // ------------------------------------------------------------- drivers
  // All drivers start and end at posedge+1.
  task automatic do_write(input logic [IW-1:0] id, input longint unsigned addr, input int len,
                          input logic [1:0] burst, input logic [63:0] d0, input logic [7:0] strb,
                          input bit bad_last, input bit stall);
    bit err = bad_last;
    longint unsigned a;
    int n;
    s_axi_awid = id; s_axi_awaddr = AW'(addr); s_axi_awlen = 8'(len);
    s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); if (++n > 50) bound_fail("aw_handshake"); end while (!s_axi_awready);
    #1 s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (stall) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a = beat_addr(addr, len, burst, i);
      s_axi_wdata = d0 + 64'(i); s_axi_wstrb = strb;
      s_axi_wlast = bad_last ? 1'b0 : (i == len); s_axi_wvalid = 1'b1;
      n = 0;
      do begin @(posedge clk); if (++n > 50) bound_fail("w_handshake"); end while (!s_axi_wready);
      #1 s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
      if (in_rng(a)) model_write(a, d0 + 64'(i), strb);
      else err = 1'b1;
    end
    exp_b.push_back('{id: id, resp: err ? 2'b10 : 2'b00});
    n = 0;
    while (exp_b.size() > 0) begin
      s_axi_bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (++n > 200) bound_fail("b_handshake");
    end
    s_axi_bready = 1'b0;
    check("bvalid_after_b", s_axi_bvalid, 1'b0);
  endtask

  task automatic issue_read(input logic [IW-1:0] id, input longint unsigned addr, input int len,
                            input logic [1:0] burst);
    longint unsigned a;
    int n;
    for (int i = 0; i <= len; i++) begin
      a = beat_addr(addr, len, burst, i);
      exp_r.push_back('{id: id, data: in_rng(a) ? model_read(a) : 64'h0,
                        resp: in_rng(a) ? 2'b00 : 2'b10, last: (i == len)});
    end
    s_axi_arid = id; s_axi_araddr = AW'(addr); s_axi_arlen = 8'(len);
    s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); if (++n > 50) bound_fail("ar_handshake"); end while (!s_axi_arready);
    #1 s_axi_arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [IW-1:0] id, input longint unsigned addr, input int len,
                         input logic [1:0] burst, input bit stall);
    int n;
    issue_read(id, addr, len, burst);
    n = 0;
    while (!s_axi_rvalid) begin
      @(posedge clk); #1;
      if (++n > 50) bound_fail("first_rvalid");
    end
    check("rd_latency", 64'(n), 64'(RDL));
    n = 0;
    while (exp_r.size() > 0) begin
      s_axi_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (++n > 300) bound_fail("r_drain");
    end
    s_axi_rready = 1'b0;
    check("rvalid_after_last", s_axi_rvalid, 1'b0);
  endtask

  // ------------------------------------------------------------- sequence
  logic [63:0] wrap_lit [4];

  initial begin
    int n;
    rstn = 1'b1;
    {s_axi_awvalid, s_axi_wvalid, s_axi_wlast, s_axi_bready, s_axi_arvalid, s_axi_rready} = '0;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awburst = '0;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arburst = '0;
    s_axi_wdata = '0; s_axi_wstrb = '0;
    #2 rstn = 1'b0;
    #10;
    check("rst_awready", s_axi_awready, 1'b1);
    check("rst_arready", s_axi_arready, 1'b1);
    check("rst_wready",  s_axi_wready,  1'b0);
    check("rst_bvalid",  s_axi_bvalid,  1'b0);
    check("rst_rvalid",  s_axi_rvalid,  1'b0);
    check("rst_rlast",   s_axi_rlast,   1'b0);
    check("rst_resps",   {s_axi_bresp, s_axi_rresp}, 4'b0);
    check("rst_ids",     {s_axi_bid, s_axi_rid}, 8'b0);
    check("rst_rdata",   s_axi_rdata,   64'h0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // INCR write then read back
    do_write(4'h5, 64'h100, 3, 2'd1, 64'hA0, 8'hFF, 1'b0, 1'b0);
    do_read (4'h5, 64'h100, 3, 2'd1, 1'b0);

    // byte-strobe merge
    do_write(4'h1, 64'h0, 0, 2'd1, 64'h1122334455667788, 8'hFF, 1'b0, 1'b0);
    do_write(4'h2, 64'h0, 0, 2'd1, 64'hFFFFFFFFDDCCBBAA, 8'h0F, 1'b0, 1'b0);
    check("merge_model", model_read(64'h0), 64'h11223344DDCCBBAA);
    do_read (4'h3, 64'h0, 0, 2'd1, 1'b0);

    // WRAP order 0x118, 0x100, 0x108, 0x110
    wrap_lit[0] = 64'h118; wrap_lit[1] = 64'h100; wrap_lit[2] = 64'h108; wrap_lit[3] = 64'h110;
    for (int k = 0; k < 4; k++) check($sformatf("wrap_addr%0d", k), beat_addr(64'h118, 3, 2'd2, k), wrap_lit[k]);
    check("wrap_beat0_model", model_read(beat_addr(64'h118, 3, 2'd2, 0)), 64'hA3);
    do_read (4'h7, 64'h118, 3, 2'd2, 1'b0);

    // straddle the top of the array: beat 0 in range, beat 1 at index DEPTH
    do_write(4'h9, 64'(DEPTH - 1) * BYTES, 1, 2'd1, 64'h5500, 8'hFF, 1'b0, 1'b0);
    check("straddle_model", model_read(64'(DEPTH - 1) * BYTES), 64'h5500);
    do_read (4'h9, 64'(DEPTH - 1) * BYTES, 1, 2'd1, 1'b0);

    // missing wlast, FIXED burst
    do_write(4'hA, 64'h200, 1, 2'd1, 64'h2000, 8'hFF, 1'b1, 1'b0);
    do_write(4'hB, 64'h300, 2, 2'd0, 64'h3000, 8'hFF, 1'b0, 1'b0);
    check("fixed_model", model_read(64'h300), 64'h3002);
    do_read (4'hB, 64'h300, 1, 2'd0, 1'b0);

    // 8-beat bursts with random stalls
    do_write(4'hC, 64'h400, 7, 2'd1, 64'hC0DE000000000000, 8'hFF, 1'b0, 1'b1);
    do_read (4'hD, 64'h400, 7, 2'd1, 1'b1);

    // reset in the middle of an 8-beat read, once beat 2 is on the bus
    issue_read(4'h4, 64'h400, 7, 2'd1);
    s_axi_rready = 1'b1;
    n = 0;
    while (exp_r.size() > 6) begin
      @(posedge clk); #1;
      if (++n > 50) bound_fail("mid_burst_reach");
    end
    #2 rstn = 1'b0;
    #1;
    check("midrst_rvalid",  s_axi_rvalid,  1'b0);
    check("midrst_rlast",   s_axi_rlast,   1'b0);
    check("midrst_arready", s_axi_arready, 1'b1);
    exp_r.delete();
    s_axi_rready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("post_rst_arready", s_axi_arready, 1'b1);
    do_read (4'h6, 64'h400, 7, 2'd1, 1'b0);

    check("leftover_expect", 64'(exp_r.size() + exp_b.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4_ram_model.md
Name: axi4_ram_model

Overview:
- Parametrised behavioural AXI4 memory slave for simulation benches. It replaces the vendor block-RAM IP wrapper.
- Adds configurable width, depth, base address, ID echo, FIXED/INCR/WRAP bursts, programmable read latency and SLVERR on out-of-range access.
- Independent read and write channels: one outstanding burst per direction. Sits behind DUT AXI4 master ports (e.g. HBM/DDR stand-ins).

Parameters:
- ADDR_WIDTH, 48, AXI address width.
- DATA_WIDTH, 64, data width in bits; power of 2, 32..1024.
- ID_WIDTH, 4, AXI ID width.
- DEPTH, 4096, number of DATA_WIDTH words.
- BASE_ADDR, 0, byte address of word 0; must be aligned to DATA_WIDTH/8.
- RD_LATENCY, 2, cycles from AR handshake to first RVALID; minimum 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- s_axi_awid/awaddr/awlen/awburst  in  ID_WIDTH/ADDR_WIDTH/8/2  write address.
- s_axi_awvalid  in  1;  s_axi_awready  out  1.
- s_axi_wdata/wstrb/wlast/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1/1;  s_axi_wready  out  1.
- s_axi_bid  out  ID_WIDTH;  s_axi_bresp  out  2;  s_axi_bvalid  out  1;  s_axi_bready  in  1.
- s_axi_arid/araddr/arlen/arburst  in  ID_WIDTH/ADDR_WIDTH/8/2  read address.
- s_axi_arvalid  in  1;  s_axi_arready  out  1.
- s_axi_rid  out  ID_WIDTH;  s_axi_rdata  out  DATA_WIDTH;  s_axi_rresp  out  2.
- s_axi_rlast/rvalid  out  1/1;  s_axi_rready  in  1.

Behaviour:
- Reset (rstn low, async): awready=arready=1; wready=bvalid=rvalid=rlast=0; bresp=rresp=0; bid=rid=0; rdata=0; both FSMs to IDLE.
- Memory contents are not cleared by reset. Reset mid-burst abandons the burst; beats already written remain.
- Beat address: word index = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8). Low address bits are ignored. AxSIZE is absent; every beat is full width.
- Burst type:
  - FIXED (0): same address for every beat.
  - INCR (1): +DATA_WIDTH/8 per beat.
  - WRAP (2): wraps within the aligned block of (len+1) beats. len must be 1, 3, 7 or 15; other lengths are treated as INCR.
  - Reserved (3): treated as INCR.
- In range means word index < DEPTH, evaluated per beat.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/burst, clear error flag, go W_DATA.
  - W_DATA: wready=1. On each W handshake, write only bytes with wstrb set, only if the beat is in range; an out-of-range beat sets the error flag. Advance the address.
  - W_DATA exit: on the beat where the count reaches len, go W_RESP regardless of wlast. wlast mismatch (early or missing) also sets the error flag.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 if error flag else 2'b00. Hold until bready, then W_IDLE.
- Read FSM R_IDLE -> R_WAIT -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On AR handshake, latch fields, load latency counter with RD_LATENCY-1, go R_WAIT.
  - R_WAIT: when the counter is 0, present beat 0 (rvalid=1), go R_DATA. RD_LATENCY=1 gives RVALID the cycle after the AR handshake.
  - R_DATA: rid=latched id; rdata=mem[index], or 0 with rresp=2'b10 if the beat is out of range; rlast=1 on beat len.
  - R_DATA backpressure: all R outputs stay stable while rvalid && !rready. On handshake, advance to the next beat the following cycle with no bubble. After the handshake of the last beat, go R_IDLE with rvalid=0.
- Read and write channels run concurrently. For the same word in the same cycle, the read returns the old data (read-before-write).
- AW and AR are accepted only in IDLE, so at most one outstanding burst per direction. A W beat before AW is not accepted (wready=0).

Test Plan:
- INCR write, awaddr=0x100, awlen=3, data 0xA0..0xA3, wstrb all ones -> BRESP=0, BID echoed. Read back same burst with RD_LATENCY=2 -> RVALID 2 cycles after AR handshake, data A0..A3, RLAST on the 4th beat.
- Write with wstrb=0x0F over 0x1122334455667788 at addr 0x0 -> read returns 0x11223344_DDCCBBAA-style merge: upper 4 bytes old, lower 4 new.
- WRAP read, araddr=0x118, arlen=3 (64-bit) -> beat order 0x118, 0x100, 0x108, 0x110.
- Write/read at word index DEPTH (addr=BASE_ADDR+DEPTH*8), len 1 straddling from index DEPTH-1 -> beat 0 written; BRESP=2'b10; read gives RRESP 0 then 2'b10 with data 0.
- Random rready/bready stalls during an 8-beat read and write -> no data change while stalled; exact beat count and order preserved.
- rstn asserted mid read burst (beat 2 of 8) -> rvalid=0 immediately; arready=1 after release; a new AR is serviced normally.
